// File: rtl/nn_pkg.sv
// Shared types and constants for the inference datapath controller.
// Holds the sequencer state encoding, buffer source selects and default layer shapes.
package nn_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MM_GO,
        ST_MM_WAIT,
        ST_RELU_GO,
        ST_RELU_WAIT,
        ST_NEXT,
        ST_AM_GO,
        ST_AM_WAIT,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    localparam logic [1:0] SRC_IMAGE = 2'd0;
    localparam logic [1:0] SRC_PING  = 2'd1;
    localparam logic [1:0] SRC_PONG  = 2'd2;

    localparam int DEF_K0 = 784;
    localparam int DEF_K1 = 64;
    localparam int DEF_K2 = 64;
    localparam int DEF_K3 = 32;
    localparam int DEF_N0 = 64;
    localparam int DEF_N1 = 64;
    localparam int DEF_N2 = 32;
    localparam int DEF_N3 = 10;

    // Entries beyond the default network come up zero-sized, so they fail validation.
    function automatic int def_k(input int i);
        case (i)
            0:       return DEF_K0;
            1:       return DEF_K1;
            2:       return DEF_K2;
            3:       return DEF_K3;
            default: return 0;
        endcase
    endfunction

    function automatic int def_n(input int i);
        case (i)
            0:       return DEF_N0;
            1:       return DEF_N1;
            2:       return DEF_N2;
            3:       return DEF_N3;
            default: return 0;
        endcase
    endfunction

    function automatic logic def_relu(input int i);
        return (i < 3);
    endfunction

    function automatic logic def_last(input int i);
        return (i == 3);
    endfunction

endpackage

// File: rtl/layer_cfg_table.sv
// Per-layer shape table: one write port, one asynchronous read port.
// Every entry resets to the default network shape.
module layer_cfg_table
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int DIM_W      = 10,
    localparam int LW        = $clog2(NUM_LAYERS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [LW-1:0]    wr_idx,
    input  logic [DIM_W-1:0] wr_k,
    input  logic [DIM_W-1:0] wr_n,
    input  logic             wr_relu,
    input  logic             wr_last,
    input  logic [LW-1:0]    rd_idx,
    output logic [DIM_W-1:0] rd_k,
    output logic [DIM_W-1:0] rd_n,
    output logic             rd_relu,
    output logic             rd_last
);

    localparam int EW = 2 * DIM_W + 2;

    logic [EW-1:0] entry_arr [NUM_LAYERS];
    logic [EW-1:0] rd_entry;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= {DIM_W'(def_k(gi)), DIM_W'(def_n(gi)),
                                  def_relu(gi), def_last(gi)};
                end else if (we && (wr_idx == LW'(gi))) begin
                    entry_reg <= {wr_k, wr_n, wr_relu, wr_last};
                end
            end

            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry = entry_arr[rd_idx];
    assign rd_k     = rd_entry[EW-1 -: DIM_W];
    assign rd_n     = rd_entry[DIM_W+1 -: DIM_W];
    assign rd_relu  = rd_entry[1];
    assign rd_last  = rd_entry[0];

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexed layer controller: drives one shared matmul and relu engine through
// the configured layers, then argmax, with a per-phase watchdog and buffer routing.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int DIM_W      = 10,
    parameter int TMO_W      = 20,
    localparam int LW        = $clog2(NUM_LAYERS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [LW-1:0]    cfg_layer,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic             cfg_relu,
    input  logic             cfg_last,
    output logic             mm_start,
    output logic [DIM_W-1:0] mm_k,
    output logic [DIM_W-1:0] mm_n,
    input  logic             mm_done,
    output logic [1:0]       mm_src_sel,
    output logic             relu_start,
    output logic [DIM_W-1:0] relu_d,
    input  logic             relu_done,
    output logic             act_dst_sel,
    output logic             argmax_start,
    output logic [DIM_W-1:0] argmax_size,
    input  logic             argmax_done,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LW-1:0]    layer_idx
);

    localparam logic [LW-1:0]    LAST_IDX  = LW'(NUM_LAYERS - 1);
    // Last WAIT cycle still tolerated; one more without a done raises the timeout.
    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);

    seq_state_t       state_reg, state_next;
    logic [LW-1:0]    layer_reg, layer_next;
    logic [TMO_W-1:0] wdog_reg, wdog_next;
    logic             busy_reg, error_reg;

    logic [LW-1:0]    rd_idx;
    logic [DIM_W-1:0] rd_k, rd_n;
    logic             rd_relu, rd_last, rd_final, entry_ok, wdog_expired;

    layer_cfg_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .DIM_W      (DIM_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (cfg_we && (state_reg == ST_IDLE) && !abort),
        .wr_idx  (cfg_layer),
        .wr_k    (cfg_k),
        .wr_n    (cfg_n),
        .wr_relu (cfg_relu),
        .wr_last (cfg_last),
        .rd_idx  (rd_idx),
        .rd_k    (rd_k),
        .rd_n    (rd_n),
        .rd_relu (rd_relu),
        .rd_last (rd_last)
    );

    // The read port looks ahead to the entry about to be validated (layer 0 at start, next at NEXT).
    always_comb begin
        rd_idx = layer_reg;
        if (state_reg == ST_IDLE) begin
            rd_idx = '0;
        end else if (state_reg == ST_NEXT) begin
            rd_idx = layer_reg + 1'b1;
        end
    end

    assign rd_final     = rd_last || (rd_idx == LAST_IDX);
    assign entry_ok     = (rd_k != '0) && (rd_n != '0) && (rd_relu || rd_final);
    assign wdog_expired = (wdog_reg == WDOG_LAST);

    always_comb begin
        state_next = state_reg;
        layer_next = layer_reg;
        wdog_next  = wdog_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    layer_next = '0;
                    state_next = entry_ok ? ST_MM_GO : ST_ERROR;
                end
            end
            ST_MM_GO: begin
                wdog_next  = '0;
                state_next = ST_MM_WAIT;
            end
            ST_MM_WAIT: begin
                wdog_next = wdog_reg + 1'b1;
                if (mm_done) begin
                    if (rd_relu)       state_next = ST_RELU_GO;
                    else if (rd_final) state_next = ST_AM_GO;
                    else               state_next = ST_NEXT;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_RELU_GO: begin
                wdog_next  = '0;
                state_next = ST_RELU_WAIT;
            end
            ST_RELU_WAIT: begin
                wdog_next = wdog_reg + 1'b1;
                if (relu_done) begin
                    state_next = rd_final ? ST_AM_GO : ST_NEXT;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_NEXT: begin
                layer_next = layer_reg + 1'b1;
                state_next = entry_ok ? ST_MM_GO : ST_ERROR;
            end
            ST_AM_GO: begin
                wdog_next  = '0;
                state_next = ST_AM_WAIT;
            end
            ST_AM_WAIT: begin
                wdog_next = wdog_reg + 1'b1;
                if (argmax_done) begin
                    state_next = ST_DONE;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (start) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            layer_reg <= '0;
            wdog_reg  <= '0;
            busy_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            layer_reg <= layer_next;
            wdog_reg  <= wdog_next;
            busy_reg  <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERROR});
            error_reg <= (state_next == ST_ERROR);
        end
    end

    // Layer L writes ping when even, pong when odd; the next layer reads what L wrote.
    assign act_dst_sel  = layer_reg[0];
    assign mm_src_sel   = (layer_reg == '0) ? SRC_IMAGE :
                          (layer_reg[0] ? SRC_PING : SRC_PONG);

    assign mm_start     = (state_reg == ST_MM_GO);
    assign relu_start   = (state_reg == ST_RELU_GO);
    assign argmax_start = (state_reg == ST_AM_GO);
    assign done         = (state_reg == ST_DONE);
    assign mm_k         = rd_k;
    assign mm_n         = rd_n;
    assign relu_d       = rd_n;
    assign argmax_size  = rd_n;
    assign busy         = busy_reg;
    assign error        = error_reg;
    assign layer_idx    = layer_reg;

endmodule
